// File: rtl/user_output_device_if.sv
// rtl/user_output_device_if.sv - register bus and interrupt bundle for the LED output device
interface user_output_device_if;
  logic [1:0] avl_address;
  logic       avl_write;
  logic [7:0] avl_writedata;
  logic       avl_read;
  logic [7:0] avl_readdata;
  logic       avl_irq;

  modport master (
    output avl_address, avl_write, avl_writedata, avl_read,
    input  avl_readdata, avl_irq
  );

  modport slave (
    input  avl_address, avl_write, avl_writedata, avl_read,
    output avl_readdata, avl_irq
  );
endinterface

// File: rtl/user_output_device.sv
// rtl/user_output_device.sv - LED driver with blink timebase, one-shot pulse and completion irq
module user_output_device #(
  parameter int TICK_DIV = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  user_output_device_if.slave     bus,
  output logic [7:0]              leds
);

  localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

  logic [TW-1:0] r_tick_cnt;
  logic [7:0]    r_led_data;
  logic [7:0]    r_blink_mask;
  logic [7:0]    r_period;
  logic [7:0]    r_blink_cnt;
  logic          r_phase;
  logic [7:0]    r_pulse_cnt;
  logic          r_irq;
  logic [7:0]    r_leds;

  logic w_tick;
  logic w_wr_led;
  logic w_wr_mask;
  logic w_wr_period;
  logic w_wr_pulse;
  logic w_irq_set;
  logic w_irq_clr;
  logic w_pulse_active;

  assign w_tick         = (r_tick_cnt == TICK_LAST);
  assign w_wr_led       = bus.avl_write && (bus.avl_address == 2'd0);
  assign w_wr_mask      = bus.avl_write && (bus.avl_address == 2'd1);
  assign w_wr_period    = bus.avl_write && (bus.avl_address == 2'd2);
  assign w_wr_pulse     = bus.avl_write && (bus.avl_address == 2'd3);
  assign w_pulse_active = (r_pulse_cnt != 8'd0);
  // A PULSE write in the expiry cycle reloads the counter, so it suppresses the set.
  assign w_irq_set      = w_tick && (r_pulse_cnt == 8'd1) && !w_wr_pulse;
  assign w_irq_clr      = (bus.avl_read || bus.avl_write) && (bus.avl_address == 2'd3);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt   <= '0;
      r_led_data   <= 8'd0;
      r_blink_mask <= 8'd0;
      r_period     <= 8'd0;
      r_blink_cnt  <= 8'd0;
      r_phase      <= 1'b0;
      r_pulse_cnt  <= 8'd0;
      r_irq        <= 1'b0;
      r_leds       <= 8'd0;
    end else begin
      r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);

      if (w_wr_led)  r_led_data   <= bus.avl_writedata;
      if (w_wr_mask) r_blink_mask <= bus.avl_writedata;

      // A PERIOD write restarts the half-period count but keeps the current phase.
      if (w_wr_period) begin
        r_period    <= bus.avl_writedata;
        r_blink_cnt <= 8'd0;
      end else if (w_tick) begin
        if (r_blink_cnt == r_period) begin
          r_blink_cnt <= 8'd0;
          r_phase     <= ~r_phase;
        end else begin
          r_blink_cnt <= r_blink_cnt + 8'd1;
        end
      end

      if (w_wr_pulse)
        r_pulse_cnt <= bus.avl_writedata;
      else if (w_tick && w_pulse_active)
        r_pulse_cnt <= r_pulse_cnt - 8'd1;

      if (w_irq_set)
        r_irq <= 1'b1;
      else if (w_irq_clr)
        r_irq <= 1'b0;

      r_leds <= (r_led_data ^ (r_blink_mask & {8{r_phase}})) | {8{w_pulse_active}};
    end
  end

  always_comb begin
    bus.avl_readdata = 8'd0;
    case (bus.avl_address)
      2'd0:    bus.avl_readdata = r_led_data;
      2'd1:    bus.avl_readdata = r_blink_mask;
      2'd2:    bus.avl_readdata = r_period;
      default: bus.avl_readdata = r_pulse_cnt;
    endcase
  end

  assign bus.avl_irq = r_irq;
  assign leds        = r_leds;

endmodule

// File: tb/tb_user_output_device.sv
// tb/tb_user_output_device.sv - directed self-checking bench for user_output_device with TICK_DIV=4
module tb_user_output_device;
  logic       clk;
  logic       reset;
  logic [7:0] leds;
  int         n_cmp;
  int         n_err;

  user_output_device_if bus_if ();

  user_output_device #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus_if),
    .leds  (leds)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    bus_if.avl_address   = a;
    bus_if.avl_writedata = d;
    bus_if.avl_write     = 1'b1;
    @(negedge clk);
    bus_if.avl_write     = 1'b0;
  endtask

  task automatic bus_read(input logic [1:0] a);
    @(negedge clk);
    bus_if.avl_address = a;
    bus_if.avl_read    = 1'b1;
    @(negedge clk);
    bus_if.avl_read    = 1'b0;
  endtask

  task automatic peek(input logic [1:0] a, output logic [7:0] d);
    bus_if.avl_address = a;
    #1 d = bus_if.avl_readdata;
  endtask

  task automatic sync_to_tick(output bit found);
    logic [7:0] v;
    found = 1'b0;
    bus_write(2'd3, 8'd2);
    for (int i = 0; i < 12 && !found; i++) begin
      peek(2'd3, v);
      if (v == 8'd1) found = 1'b1;
      else @(negedge clk);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    logic [7:0] v;
    logic [7:0] v1;
    logic [7:0] v2;
    int cnt;
    int irq_hi;
    bit found;

    n_cmp = 0;
    n_err = 0;
    reset = 1'b1;
    bus_if.avl_address   = 2'd0;
    bus_if.avl_write     = 1'b0;
    bus_if.avl_writedata = 8'd0;
    bus_if.avl_read      = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_leds", leds, 8'h00);
    check("rst_irq", bus_if.avl_irq, 1'b0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], v);
      check($sformatf("rst_reg%0d", a), v, 8'h00);
    end

    // LED_DATA write latency and readback
    bus_write(2'd0, 8'hA5);
    check("led_lat_first_edge", leds, 8'h00);
    @(negedge clk);
    check("led_lat_second_edge", leds, 8'hA5);
    peek(2'd0, v);
    check("led_readback", v, 8'hA5);

    // Simultaneous read and write: readdata shows the old value
    @(negedge clk);
    bus_if.avl_address   = 2'd0;
    bus_if.avl_writedata = 8'h3C;
    bus_if.avl_write     = 1'b1;
    bus_if.avl_read      = 1'b1;
    #1 check("rw_pre_write", bus_if.avl_readdata, 8'hA5);
    @(negedge clk);
    bus_if.avl_write = 1'b0;
    bus_if.avl_read  = 1'b0;
    peek(2'd0, v);
    check("rw_post_write", v, 8'h3C);

    // Blink: mask 0x0F, PERIOD 1 -> half-period of 8 clocks
    bus_write(2'd0, 8'h00);
    bus_write(2'd1, 8'h0F);
    bus_write(2'd2, 8'h01);
    peek(2'd2, v);
    check("period_readback", v, 8'h01);
    v1 = leds;
    cnt = 0;
    while (leds == v1 && cnt < 40) begin @(negedge clk); cnt++; end
    v1 = leds;
    cnt = 0;
    while (leds == v1 && cnt < 40) begin @(negedge clk); cnt++; end
    check("blink_interval_a", cnt, 8);
    v2 = leds;
    cnt = 0;
    while (leds == v2 && cnt < 40) begin @(negedge clk); cnt++; end
    check("blink_interval_b", cnt, 8);
    check("blink_alternates", v1 ^ v2, 8'h0F);
    check("blink_upper_zero", (v1 | v2) & 8'hF0, 8'h00);

    // Pulse of 3 ticks over data 0x01
    bus_write(2'd1, 8'h00);
    bus_write(2'd0, 8'h01);
    bus_write(2'd3, 8'h03);
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (leds == 8'hFF) cnt++;
      else if (cnt > 0) break;
    end
    check("pulse_len_in_9_12", (cnt >= 9 && cnt <= 12), 1'b1);
    check("pulse_after_leds", leds, 8'h01);
    check("pulse_irq_set", bus_if.avl_irq, 1'b1);
    peek(2'd3, v);
    check("pulse_cnt_zero", v, 8'h00);
    bus_read(2'd3);
    check("irq_cleared_by_read", bus_if.avl_irq, 1'b0);

    // Cancel a pulse with PULSE 0: no irq
    bus_write(2'd3, 8'h05);
    repeat (6) @(negedge clk);
    bus_write(2'd3, 8'h00);
    irq_hi = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.avl_irq) irq_hi++;
    end
    check("cancel_no_irq", irq_hi, 0);
    check("cancel_leds", leds, 8'h01);

    // Read of addr 3 on the expiry tick: set wins, next read clears
    sync_to_tick(found);
    check("sync_found_a", found, 1'b1);
    bus_if.avl_address = 2'd3;
    bus_if.avl_read    = 1'b1;
    @(negedge clk);
    bus_if.avl_read    = 1'b0;
    check("set_beats_clear", bus_if.avl_irq, 1'b1);
    bus_read(2'd3);
    check("second_read_clears", bus_if.avl_irq, 1'b0);

    // PULSE write on the expiry tick: reload wins, no irq
    sync_to_tick(found);
    check("sync_found_b", found, 1'b1);
    bus_if.avl_address   = 2'd3;
    bus_if.avl_writedata = 8'h04;
    bus_if.avl_write     = 1'b1;
    @(negedge clk);
    bus_if.avl_write     = 1'b0;
    check("reload_no_irq", bus_if.avl_irq, 1'b0);
    peek(2'd3, v);
    check("reload_value", v, 8'h04);

    // Reset mid-blink with a pulse active
    bus_write(2'd1, 8'hFF);
    bus_write(2'd2, 8'h00);
    bus_write(2'd3, 8'h09);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_leds", leds, 8'h00);
    check("reset_irq", bus_if.avl_irq, 1'b0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      peek(a[1:0], v);
      check($sformatf("post_rst_reg%0d", a), v, 8'h00);
    end
    irq_hi = 0;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus_if.avl_irq) irq_hi++;
      if (leds != 8'h00) cnt++;
    end
    check("post_rst_no_irq", irq_hi, 0);
    check("post_rst_leds_dark", cnt, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
